// File: rtl/sync_adder_pkg.sv
// Shared helpers for the carry-select registered adder.
package sync_adder_pkg;

    // Number of carry-select segments needed to cover a WIDTH-bit operand.
    function automatic int unsigned seg_count(input int unsigned width, input int unsigned seg_w);
        return (width + seg_w - 1) / seg_w;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Plain W-bit ripple-carry adder used as the building block of each carry-select segment.
module adder_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    always_comb begin
        logic c;
        s = '0;
        c = cin;
        for (int i = 0; i < int'(W); i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/sync_adder.sv
// Fully registered unsigned adder: operand register, carry-select add, result register (latency 2).
module sync_adder
    import sync_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned SEG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    localparam int unsigned NSEG = seg_count(WIDTH, SEG_W);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_c;
    logic [NSEG-1:0]  carry_c;

    // Stage 1: operand capture
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= i_a;
            b_q <= i_b;
        end
    end

    // Carry-select chain; carry_c[g] is the carry-out of segment g
    for (genvar g = 0; g < int'(NSEG); g++) begin : g_seg
        localparam int unsigned LO = int'(g) * SEG_W;
        localparam int unsigned SW = (LO + SEG_W > WIDTH) ? (WIDTH - LO) : SEG_W;

        if (g == 0) begin : g_ripple
            adder_slice #(.W(SW)) u_slice (
                .a    (a_q[LO +: SW]),
                .b    (b_q[LO +: SW]),
                .cin  (1'b0),
                .s    (sum_c[LO +: SW]),
                .cout (carry_c[0])
            );
        end else begin : g_select
            logic [SW-1:0] s0_c;
            logic [SW-1:0] s1_c;
            logic          c0_c;
            logic          c1_c;

            adder_slice #(.W(SW)) u_slice0 (
                .a    (a_q[LO +: SW]),
                .b    (b_q[LO +: SW]),
                .cin  (1'b0),
                .s    (s0_c),
                .cout (c0_c)
            );

            adder_slice #(.W(SW)) u_slice1 (
                .a    (a_q[LO +: SW]),
                .b    (b_q[LO +: SW]),
                .cin  (1'b1),
                .s    (s1_c),
                .cout (c1_c)
            );

            assign sum_c[LO +: SW] = carry_c[g-1] ? s1_c : s0_c;
            assign carry_c[g]      = carry_c[g-1] ? c1_c : c0_c;
        end
    end

    // Stage 2: result capture; MSB is the final carry-out
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sum <= '0;
        end else begin
            o_sum <= {carry_c[NSEG-1], sum_c};
        end
    end

endmodule

// File: tb/tb_sync_adder.sv
// Scoreboard bench for sync_adder: directed scenarios on 12/4 plus random sweeps on 12/4, 13/4 and 1/1.
`timescale 1ns/1ps
module tb_sync_adder;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [11:0] i_a;
    logic [11:0] i_b;
    logic [12:0] o_sum;
    logic [12:0] a13;
    logic [12:0] b13;
    logic [13:0] sum13;
    logic        a1;
    logic        b1;
    logic [1:0]  sum1;

    logic [12:0] q12[$];
    logic [13:0] q13[$];
    logic [1:0]  q1[$];

    int n_chk = 0;
    int n_err = 0;

    always #10 i_clk = ~i_clk;

    sync_adder #(.WIDTH(12), .SEG_W(4)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_a(i_a), .i_b(i_b), .o_sum(o_sum)
    );

    sync_adder #(.WIDTH(13), .SEG_W(4)) u_dut13 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_a(a13), .i_b(b13), .o_sum(sum13)
    );

    sync_adder #(.WIDTH(1), .SEG_W(1)) u_dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_a(a1), .i_b(b1), .o_sum(sum1)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    // Drive one cycle on all instances and push expected results; reset flushes everything in flight.
    task automatic drive(input logic [11:0] a, input logic [11:0] b, input logic rst_n,
                         input logic [12:0] x13, input logic [12:0] y13,
                         input logic x1, input logic y1);
        i_a = a; i_b = b; i_rst_n = rst_n;
        a13 = x13; b13 = y13; a1 = x1; b1 = y1;
        while (q12.size() >= 2) void'(q12.pop_front());
        while (q13.size() >= 2) void'(q13.pop_front());
        while (q1.size()  >= 2) void'(q1.pop_front());
        if (!rst_n) begin
            foreach (q12[k]) q12[k] = '0;
            foreach (q13[k]) q13[k] = '0;
            foreach (q1[k])  q1[k]  = '0;
            if (q12.size() == 0) q12.push_back('0);
            if (q13.size() == 0) q13.push_back('0);
            if (q1.size()  == 0) q1.push_back('0);
            q12.push_back('0);
            q13.push_back('0);
            q1.push_back('0);
        end else begin
            q12.push_back(13'(a) + 13'(b));
            q13.push_back(14'(x13) + 14'(y13));
            q1.push_back(2'(x1) + 2'(y1));
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(12'd5, 12'd7, (i >= 2), 13'd0, 13'd0, 1'b0, 1'b0);
            if (q12.size() == 2) begin
                exp = q12.pop_front();
                n_chk++;
                if (o_sum !== exp) begin
                    n_err++;
                    $display("FAIL reset[%0d]: o_sum=%0d expected %0d", i, o_sum, exp);
                end
            end
        end
    endtask

    task automatic test_staggered();
        logic [11:0] sa [8] = '{12'd0, 12'd0, 12'd0, 12'd20, 12'd20, 12'd20, 12'd20, 12'd20};
        logic [11:0] sb [8] = '{12'd0, 12'd0, 12'd0, 12'd0,  12'd0,  12'd70, 12'd70, 12'd70};
        logic [12:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(sa[i], sb[i], 1'b1, 13'd0, 13'd0, 1'b0, 1'b0);
            if (q12.size() == 2) begin
                exp = q12.pop_front();
                n_chk++;
                if (o_sum !== exp) begin
                    n_err++;
                    $display("FAIL staggered[%0d]: o_sum=%0d expected %0d", i, o_sum, exp);
                end
            end
        end
    endtask

    task automatic test_full_scale();
        logic [11:0] sa [5] = '{12'hFFF, 12'hFFF, 12'd0, 12'd1,   12'hFFF};
        logic [11:0] sb [5] = '{12'hFFF, 12'd1,   12'd0, 12'hFFF, 12'hFFF};
        logic [12:0] exp;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(sa[i], sb[i], 1'b1, 13'h1FFF, 13'd1, 1'b1, 1'b1);
            else       drive(12'd0, 12'd0, 1'b1, 13'h1FFF, 13'd1, 1'b1, 1'b1);
            if (q12.size() == 2) begin
                exp = q12.pop_front();
                n_chk++;
                if (o_sum !== exp) begin
                    n_err++;
                    $display("FAIL full_scale[%0d]: o_sum=%0d expected %0d", i, o_sum, exp);
                end
            end
        end
        if (q12.size() != 1) begin
            n_err++;
            $display("FAIL full_scale_sb: queue depth %0d expected 1", q12.size());
        end
        n_chk++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] sa [6] = '{12'd1, 12'd3, 12'd100, 12'd0, 12'd0, 12'd0};
        logic [11:0] sb [6] = '{12'd2, 12'd4, 12'd200, 12'd0, 12'd0, 12'd0};
        logic [12:0] exp;
        for (int i = 0; i < 6; i++) begin
            drive(sa[i], sb[i], 1'b1, 13'd0, 13'd0, 1'b0, 1'b0);
            if (q12.size() == 2) begin
                exp = q12.pop_front();
                n_chk++;
                if (o_sum !== exp) begin
                    n_err++;
                    $display("FAIL back_to_back[%0d]: o_sum=%0d expected %0d", i, o_sum, exp);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] sa [7] = '{12'd10, 12'd30, 12'd50, 12'd70, 12'd90,  12'd1, 12'd0};
        logic [11:0] sb [7] = '{12'd20, 12'd40, 12'd60, 12'd80, 12'd100, 12'd1, 12'd0};
        logic [12:0] exp;
        for (int i = 0; i < 7; i++) begin
            drive(sa[i], sb[i], (i != 2), 13'd0, 13'd0, 1'b0, 1'b0);
            if (q12.size() == 2) begin
                exp = q12.pop_front();
                n_chk++;
                if (o_sum !== exp) begin
                    n_err++;
                    $display("FAIL mid_reset[%0d]: o_sum=%0d expected %0d", i, o_sum, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [12:0] e12;
        logic [13:0] e13;
        logic [1:0]  e1;
        drive(12'd0, 12'd0, 1'b0, 13'd0, 13'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            drive(12'($urandom), 12'($urandom), 1'b1,
                  13'($urandom), 13'($urandom), 1'($urandom), 1'($urandom));
            if (q12.size() == 2) begin
                e12 = q12.pop_front();
                e13 = q13.pop_front();
                e1  = q1.pop_front();
                n_chk += 3;
                if (o_sum !== e12) begin
                    n_err++;
                    $display("FAIL random12[%0d]: o_sum=%0d expected %0d", i, o_sum, e12);
                end
                if (sum13 !== e13) begin
                    n_err++;
                    $display("FAIL random13[%0d]: o_sum=%0d expected %0d", i, sum13, e13);
                end
                if (sum1 !== e1) begin
                    n_err++;
                    $display("FAIL random1[%0d]: o_sum=%0d expected %0d", i, sum1, e1);
                end
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_a = '0; i_b = '0; a13 = '0; b13 = '0; a1 = 1'b0; b1 = 1'b0;
        test_reset();
        test_staggered();
        test_full_scale();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
